// File: rtl/branch_predictor_bht.sv
// Branch history table of 2-bit saturating counters: predict at fetch, train at EX.
// Prediction and mispredict flag are registered (1 cycle); no backpressure, every cycle accepted.
module branch_predictor_bht #(
  parameter int INDEX_BITS = 6,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic            branch_out,
  output logic            mispredict,
  output logic            init_busy,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int N = 2 ** INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;
  localparam logic [INDEX_BITS-1:0] IDX_ONE  = {{(INDEX_BITS-1){1'b0}}, 1'b1};

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t                 state_q, state_d;
  logic [INDEX_BITS-1:0]  init_idx_q, init_idx_d;
  logic                   pred_valid_q, pred_valid_d;
  logic                   pred_taken_q, pred_taken_d;
  logic                   mispredict_q, mispredict_d;
  logic [31:0]            stat_branches_q, stat_branches_d;
  logic [31:0]            stat_mispredicts_q, stat_mispredicts_d;

  logic [1:0]             table_q [N];
  logic                   wr_en;
  logic [INDEX_BITS-1:0]  wr_idx;
  logic [1:0]             wr_dat;
  logic [INDEX_BITS-1:0]  fetch_idx, ex_idx;
  logic [1:0]             ex_cnt;
  logic                   resolved;
  logic                   unused_pc_bits;

  assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
  assign ex_idx    = ex_pc[INDEX_BITS+1:2];
  assign ex_cnt    = table_q[ex_idx];
  assign resolved  = ex_valid & ex_is_branch;
  assign unused_pc_bits = ^{fetch_pc[XLEN-1:INDEX_BITS+2], fetch_pc[1:0],
                            ex_pc[XLEN-1:INDEX_BITS+2], ex_pc[1:0]};

  always_comb begin
    state_d            = state_q;
    init_idx_d         = init_idx_q;
    wr_en              = 1'b0;
    wr_idx             = ex_idx;
    wr_dat             = ex_cnt;
    pred_valid_d       = fetch_valid;
    pred_taken_d       = 1'b0;
    mispredict_d       = resolved & (ex_pred_taken != branch_out);
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;

    case (state_q)
      S_INIT: begin
        wr_en      = 1'b1;
        wr_idx     = init_idx_q;
        wr_dat     = 2'b01;
        init_idx_d = init_idx_q + IDX_ONE;
        if (init_idx_q == LAST_IDX) state_d = S_READY;
      end
      default: begin
        pred_taken_d = fetch_valid & table_q[fetch_idx][1];
        if (resolved) begin
          wr_en = 1'b1;
          if (branch_out) wr_dat = (ex_cnt == 2'b11) ? 2'b11 : ex_cnt + 2'b01;
          else            wr_dat = (ex_cnt == 2'b00) ? 2'b00 : ex_cnt - 2'b01;
        end
      end
    endcase

    if (resolved && stat_branches_q != 32'hFFFF_FFFF)
      stat_branches_d = stat_branches_q + 32'd1;
    if (mispredict_d && stat_mispredicts_q != 32'hFFFF_FFFF)
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_INIT;
      init_idx_q         <= '0;
      pred_valid_q       <= 1'b0;
      pred_taken_q       <= 1'b0;
      mispredict_q       <= 1'b0;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      state_q            <= state_d;
      init_idx_q         <= init_idx_d;
      pred_valid_q       <= pred_valid_d;
      pred_taken_q       <= pred_taken_d;
      mispredict_q       <= mispredict_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  // Counter array has no reset; INIT walks every entry to weakly-not-taken.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) table_q[wr_idx] <= wr_dat;
  end

  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign mispredict       = mispredict_q;
  assign init_busy        = (state_q == S_INIT);
  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: init timing, training, saturation, mispredict stats.
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid, pred_taken;
  logic        ex_valid, ex_is_branch, ex_pred_taken, branch_out;
  logic [31:0] ex_pc;
  logic        mispredict, init_busy;
  logic [31:0] stat_branches, stat_mispredicts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor_bht #(.INDEX_BITS(6), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .branch_out(branch_out),
    .mispredict(mispredict), .init_busy(init_busy),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic predict(input logic [31:0] pc, output logic v, output logic t);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    tick();
    fetch_valid = 1'b0;
    v = pred_valid;
    t = pred_taken;
  endtask

  task automatic update(input logic [31:0] pc, input logic taken, input logic pred);
    ex_valid      = 1'b1;
    ex_is_branch  = 1'b1;
    ex_pc         = pc;
    branch_out    = taken;
    ex_pred_taken = pred;
    tick();
    ex_valid      = 1'b0;
    ex_is_branch  = 1'b0;
  endtask

  // Counts cycles with init_busy high; gives up after 200.
  task automatic wait_init(output int cyc);
    cyc = 0;
    while (init_busy === 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    logic v, t;
    rst = 1'b1;
    tick();
    checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL reset_pred_valid got=%b exp=0", pred_valid); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got=%b exp=0", pred_taken); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict got=%b exp=0", mispredict); end
    checks++; if (stat_branches !== 32'd0) begin errors++; $display("FAIL reset_stat_br got=%h exp=0", stat_branches); end
    checks++; if (stat_mispredicts !== 32'd0) begin errors++; $display("FAIL reset_stat_mp got=%h exp=0", stat_mispredicts); end
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_init_busy got=%b exp=1", init_busy); end
    rst = 1'b0;
    predict(32'h0000_0040, v, t);
    checks++; if (v !== 1'b1 || t !== 1'b0) begin errors++; $display("FAIL init_predict got=%b%b exp=10", v, t); end
    wait_init(cyc);
    cyc = cyc + 1;
    checks++; if (cyc !== 64) begin errors++; $display("FAIL init_busy_cycles got=%0d exp=64", cyc); end
    foreach (pcs_r[i]) begin
      predict(pcs_r[i], v, t);
      checks++; if (v !== 1'b1 || t !== 1'b0) begin errors++; $display("FAIL ready_predict pc=%h got=%b%b exp=10", pcs_r[i], v, t); end
    end
    tick();
    checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL idle_pred_valid got=%b exp=0", pred_valid); end
  endtask

  logic [31:0] pcs_r [4] = '{32'h0000_0000, 32'h0000_0040, 32'h0000_00FC, 32'hFFFF_FF03};

  task automatic test_train_alias();
    logic v, t;
    update(32'h0000_0040, 1'b1, 1'b0);
    update(32'h0000_0040, 1'b1, 1'b0);
    predict(32'h0000_0040, v, t);
    checks++; if (t !== 1'b1) begin errors++; $display("FAIL train_pc40 got=%b exp=1", t); end
    predict(32'h0000_0044, v, t);
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL train_pc44 got=%b exp=0", t); end
    predict(32'h0000_0140, v, t);
    checks++; if (t !== 1'b1) begin errors++; $display("FAIL alias_pc140 got=%b exp=1", t); end
  endtask

  task automatic test_saturation();
    logic v, t;
    for (int i = 0; i < 4; i++) update(32'h0000_0080, 1'b1, 1'b1);
    update(32'h0000_0080, 1'b0, 1'b1);
    predict(32'h0000_0080, v, t);
    checks++; if (t !== 1'b1) begin errors++; $display("FAIL sat_st_to_wt got=%b exp=1", t); end
    update(32'h0000_0080, 1'b0, 1'b1);
    predict(32'h0000_0080, v, t);
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL sat_wnt got=%b exp=0", t); end
    update(32'h0000_0080, 1'b0, 1'b0);
    predict(32'h0000_0080, v, t);
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL sat_snt got=%b exp=0", t); end
    update(32'h0000_0080, 1'b0, 1'b0);
    update(32'h0000_0080, 1'b1, 1'b0);
    predict(32'h0000_0080, v, t);
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL sat_floor got=%b exp=0", t); end
  endtask

  task automatic test_mispredict_stats();
    logic [31:0] b0, m0;
    b0 = stat_branches;
    m0 = stat_mispredicts;
    update(32'h0000_00C0, 1'b0, 1'b1);
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL mp_pulse got=%b exp=1", mispredict); end
    checks++; if (stat_branches !== b0 + 32'd1) begin errors++; $display("FAIL mp_stat_br got=%h exp=%h", stat_branches, b0 + 32'd1); end
    checks++; if (stat_mispredicts !== m0 + 32'd1) begin errors++; $display("FAIL mp_stat_mp got=%h exp=%h", stat_mispredicts, m0 + 32'd1); end
    ex_valid = 1'b1; ex_is_branch = 1'b0; ex_pred_taken = 1'b1; branch_out = 1'b0;
    tick();
    ex_valid = 1'b0;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL nonbr_mp got=%b exp=0", mispredict); end
    checks++; if (stat_branches !== b0 + 32'd1 || stat_mispredicts !== m0 + 32'd1) begin
      errors++; $display("FAIL nonbr_stats got=%h/%h exp=%h/%h", stat_branches, stat_mispredicts, b0 + 32'd1, m0 + 32'd1); end
    ex_valid = 1'b0; ex_is_branch = 1'b1;
    tick();
    ex_is_branch = 1'b0;
    checks++; if (stat_branches !== b0 + 32'd1) begin errors++; $display("FAIL novalid_stat_br got=%h exp=%h", stat_branches, b0 + 32'd1); end
    update(32'h0000_00C0, 1'b1, 1'b1);
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL correct_mp got=%b exp=0", mispredict); end
    checks++; if (stat_branches !== b0 + 32'd2 || stat_mispredicts !== m0 + 32'd1) begin
      errors++; $display("FAIL correct_stats got=%h/%h exp=%h/%h", stat_branches, stat_mispredicts, b0 + 32'd2, m0 + 32'd1); end
  endtask

  task automatic test_back_to_back();
    logic v, t;
    fetch_valid = 1'b1; fetch_pc = 32'h0000_0100;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h0000_0100;
    branch_out = 1'b1; ex_pred_taken = 1'b0;
    tick();
    fetch_valid = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0;
    checks++; if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin errors++; $display("FAIL rbw_same_cycle got=%b%b exp=10", pred_valid, pred_taken); end
    predict(32'h0000_0100, v, t);
    checks++; if (t !== 1'b1) begin errors++; $display("FAIL rbw_next got=%b exp=1", t); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    logic v, t;
    update(32'h0000_0100, 1'b1, 1'b1);
    predict(32'h0000_0100, v, t);
    checks++; if (t !== 1'b1) begin errors++; $display("FAIL pre_reset_pred got=%b exp=1", t); end
    rst = 1'b1;
    fetch_valid = 1'b1; fetch_pc = 32'h0000_0100;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h0000_0100;
    ex_pred_taken = 1'b1; branch_out = 1'b0;
    tick();
    rst = 1'b0; fetch_valid = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0;
    checks++; if (pred_valid !== 1'b0 || pred_taken !== 1'b0 || mispredict !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got=%b%b%b exp=000", pred_valid, pred_taken, mispredict); end
    checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      errors++; $display("FAIL midrst_stats got=%h/%h exp=0/0", stat_branches, stat_mispredicts); end
    wait_init(cyc);
    checks++; if (cyc !== 64) begin errors++; $display("FAIL midrst_init_cycles got=%0d exp=64", cyc); end
    predict(32'h0000_0100, v, t);
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL midrst_retrained got=%b exp=0", t); end
    dut.stat_mispredicts_q = 32'hFFFF_FFFF;
    dut.stat_branches_q    = 32'hFFFF_FFFE;
    update(32'h0000_0200, 1'b0, 1'b1);
    checks++; if (stat_mispredicts !== 32'hFFFF_FFFF || stat_branches !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sat_stats_1 got=%h/%h exp=ffffffff/ffffffff", stat_branches, stat_mispredicts); end
    update(32'h0000_0200, 1'b0, 1'b1);
    checks++; if (stat_mispredicts !== 32'hFFFF_FFFF || stat_branches !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sat_stats_2 got=%h/%h exp=ffffffff/ffffffff", stat_branches, stat_mispredicts); end
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_pc = '0;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = '0;
    ex_pred_taken = 1'b0; branch_out = 1'b0;
    test_reset();
    test_train_alias();
    test_saturation();
    test_mispredict_stats();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
